mem_stage: RTL and testbench

- Memory-access pipeline stage between EX and WB.
- Accepts the EX-to-MEM bus and, for loads, waits for the data SRAM response, holding it in a buffer if needed.
- Byte/halfword-extends the loaded data and forms the 70-bit MEM-to-WB bus: {gr_we, dest, final_result, pc}.
- Drives MEM-stage forwarding and load-use stall information back to ID.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage_load_ext.sv | 33 +++
 rtl/mem_stage.sv | 86 ++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: EX-to-MEM / MEM-to-WB bus widths, field layouts and load opcodes.
package mem_stage_pkg;

    localparam int ES_BUS_W = 75;
    localparam int MS_BUS_W = 70;

    // Field offsets inside the EX-to-MEM bus
    localparam int ES_REQ_BIT      = 74;
    localparam int ES_LD_OP_LSB    = 71;
    localparam int ES_RES_MEM_BIT  = 70;
    localparam int ES_GR_WE_BIT    = 69;
    localparam int ES_DEST_LSB     = 64;
    localparam int ES_ALU_LSB      = 32;
    localparam int ES_PC_LSB       = 0;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b101,
        LD_HU = 3'b110
    } ld_op_e;

    // ld_op stays a plain vector: unlisted codes are legal and load a whole word
    typedef struct packed {
        logic        req_issued;
        logic [2:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, bus, data-SRAM response and ID feedback signals seen by the MEM stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic                ms_allowin;
    logic                ws_allowin;
    logic                ms_to_ws_valid;
    logic [MS_BUS_W-1:0] ms_to_ws_bus;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;
    logic [4:0]          ms_to_ds_dest;
    logic [31:0]         ms_to_ds_value;
    logic                ms_to_ds_ld_block;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value,
               ms_to_ds_ld_block
    );

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value,
               ms_to_ds_ld_block
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Byte/halfword lane select and sign/zero extension of a loaded word; purely combinational.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            2'b11:   byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (ld_op)
            LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_data = {24'd0, byte_sel};
            LD_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_data = {16'd0, half_sel};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM responses, extends loads, forwards results to ID.
// Define MS_RDATA_BUF_EN to capture one-cycle responses while WB is stalled.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    mem_stage_if.slave pipe
);

    logic        ms_valid;
    es_bus_t     ms_bus_r;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ld_data;
    logic [31:0] ext_data;
    logic [31:0] final_result;
    logic        fwd_en;
    ms_bus_t     ws_bus;

`ifdef MS_RDATA_BUF_EN
    logic        buf_valid;
    logic [31:0] rdata_buf;

    assign ms_ready_go = !ms_bus_r.req_issued | buf_valid | pipe.data_sram_data_ok;
    assign ld_data     = buf_valid ? rdata_buf : pipe.data_sram_rdata;

    // A response arriving while WB stalls is kept here; one leaving in the same cycle bypasses it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            rdata_buf <= 32'd0;
        end else if (ms_to_ws_valid && pipe.ws_allowin) begin
            buf_valid <= 1'b0;
        end else if (ms_valid && ms_bus_r.req_issued && pipe.data_sram_data_ok
                     && !buf_valid && !pipe.ws_allowin) begin
            buf_valid <= 1'b1;
            rdata_buf <= pipe.data_sram_rdata;
        end
    end
`else
    // The SRAM side holds data_ok/rdata until the instruction leaves
    assign ms_ready_go = !ms_bus_r.req_issued | pipe.data_sram_data_ok;
    assign ld_data     = pipe.data_sram_rdata;
`endif

    assign ms_allowin     = !ms_valid | (ms_ready_go & pipe.ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            ms_bus_r <= '0;
        end else if (ms_allowin) begin
            ms_valid <= pipe.es_to_ms_valid;
            if (pipe.es_to_ms_valid) begin
                ms_bus_r <= es_bus_t'(pipe.es_to_ms_bus);
            end
        end
    end

    load_ext u_load_ext (
        .ld_op    (ms_bus_r.ld_op),
        .addr     (ms_bus_r.alu_result[1:0]),
        .rdata    (ld_data),
        .ext_data (ext_data)
    );

    assign final_result = ms_bus_r.res_from_mem ? ext_data : ms_bus_r.alu_result;

    assign ws_bus.gr_we        = ms_bus_r.gr_we;
    assign ws_bus.dest         = ms_bus_r.dest;
    assign ws_bus.final_result = final_result;
    assign ws_bus.pc           = ms_bus_r.pc;

    assign fwd_en = ms_valid & ms_bus_r.gr_we;

    assign pipe.ms_allowin        = ms_allowin;
    assign pipe.ms_to_ws_valid    = ms_to_ws_valid;
    assign pipe.ms_to_ws_bus      = ws_bus;
    assign pipe.ms_to_ds_dest     = fwd_en ? ms_bus_r.dest : 5'd0;
    assign pipe.ms_to_ds_value    = fwd_en ? final_result : 32'd0;
    assign pipe.ms_to_ds_ld_block = fwd_en & ms_bus_r.res_from_mem & !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/stall/reset cases, then random traffic against a reference model.
module tb_mem_stage;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_stage_if ms_if ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (ms_if.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [69:0] actual, input logic [69:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then return at the falling edge
    task automatic applyStimulus(input logic valid, input logic [74:0] bus, input logic ws,
                                 input logic ok, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        ms_if.es_to_ms_valid    = valid;
        ms_if.es_to_ms_bus      = bus;
        ms_if.ws_allowin        = ws;
        ms_if.data_sram_data_ok = ok;
        ms_if.data_sram_rdata   = rdata;
        @(negedge clk);
    endtask

    function automatic logic [74:0] es_word(input logic req, input logic [2:0] op, input logic res,
                                            input logic we, input logic [4:0] dest,
                                            input logic [31:0] alu, input logic [31:0] pc);
        return {req, op, res, we, dest, alu, pc};
    endfunction

    // Reference result: shift the addressed lane down, mask it, then wrap negative values for signed loads
    function automatic logic [31:0] ref_final(input logic res, input logic [2:0] op,
                                              input logic [31:0] alu, input logic [31:0] rdata);
        logic [31:0] v;
        if (!res) return alu;
        case (op)
            3'b001, 3'b101: begin
                v = (rdata >> (8 * int'(alu[1:0]))) & 32'h0000_00FF;
                if (op == 3'b001 && v >= 32'd128) v = v - 32'd256;
            end
            3'b010, 3'b110: begin
                v = (rdata >> (16 * int'(alu[1]))) & 32'h0000_FFFF;
                if (op == 3'b010 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic runLoad(input string tag, input logic [2:0] op, input logic [31:0] alu,
                           input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b1, es_word(1'b1, op, 1'b1, 1'b1, 5'd7, alu, 32'h1c00_0100), 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b0, 32'd0);
        checkOutput({tag, "_ld_block"}, ms_if.ms_to_ds_ld_block, 1'b1);
        checkOutput({tag, "_wait_valid"}, ms_if.ms_to_ws_valid, 1'b0);
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b1, rdata);
        checkOutput({tag, "_valid"}, ms_if.ms_to_ws_valid, 1'b1);
        checkOutput({tag, "_result"}, ms_if.ms_to_ws_bus[63:32], expected);
        checkOutput({tag, "_fwd_value"}, ms_if.ms_to_ds_value, expected);
    endtask

    // Random-phase model state: the instruction held in MEM and when its response shows up
    logic        occ_valid;
    logic [74:0] occ_bus;
    int          wait_cnt;
    logic [31:0] resp_data;

    initial begin
        logic        es_valid, ws, ok, ready, exp_valid, exp_allowin, fwd;
        logic [31:0] rdata, exp_final, pc;
        logic [74:0] new_bus;
        logic        req, res, we;
        logic [2:0]  op;

        ms_if.es_to_ms_valid    = 1'b0;
        ms_if.es_to_ms_bus      = '0;
        ms_if.ws_allowin        = 1'b0;
        ms_if.data_sram_data_ok = 1'b0;
        ms_if.data_sram_rdata   = '0;

        #12;
        checkOutput("rst_allowin", ms_if.ms_allowin, 1'b1);
        checkOutput("rst_valid", ms_if.ms_to_ws_valid, 1'b0);
        checkOutput("rst_bus", ms_if.ms_to_ws_bus, 70'd0);
        checkOutput("rst_dest", ms_if.ms_to_ds_dest, 5'd0);
        checkOutput("rst_value", ms_if.ms_to_ds_value, 32'd0);
        checkOutput("rst_ld_block", ms_if.ms_to_ds_ld_block, 1'b0);
        #2 resetn = 1'b1;

        // Plain ALU instruction passes straight through
        applyStimulus(1'b1, es_word(1'b0, 3'b000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000), 1'b1, 1'b0, 32'd0);
        checkOutput("alu_allowin", ms_if.ms_allowin, 1'b1);
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("alu_valid", ms_if.ms_to_ws_valid, 1'b1);
        checkOutput("alu_bus", ms_if.ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
        checkOutput("alu_fwd_dest", ms_if.ms_to_ds_dest, 5'd5);
        checkOutput("alu_ld_block", ms_if.ms_to_ds_ld_block, 1'b0);

        runLoad("ld_b", 3'b001, 32'h0000_2003, 32'h80FF_0011, 32'hFFFF_FF80);
        runLoad("ld_bu", 3'b101, 32'h0000_2003, 32'h80FF_0011, 32'h0000_0080);
        runLoad("ld_hu", 3'b110, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF);
        runLoad("ld_h", 3'b010, 32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF);
        runLoad("ld_b_lane0", 3'b001, 32'h0000_2000, 32'h80FF_0011, 32'h0000_0011);

        // Response arrives while WB stalls; result must stay put until WB accepts it
        applyStimulus(1'b1, es_word(1'b1, 3'b000, 1'b1, 1'b1, 5'd9, 32'h0000_1000, 32'h1c00_0200), 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 75'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
        checkOutput("stall_valid0", ms_if.ms_to_ws_valid, 1'b1);
        checkOutput("stall_result0", ms_if.ms_to_ws_bus[63:32], 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
`ifdef MS_RDATA_BUF_EN
            applyStimulus(1'b0, 75'd0, 1'b0, 1'b0, 32'h1111_1111 * (i + 1));
`else
            applyStimulus(1'b0, 75'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
`endif
            checkOutput("stall_valid", ms_if.ms_to_ws_valid, 1'b1);
            checkOutput("stall_result", ms_if.ms_to_ws_bus[63:32], 32'hCAFE_F00D);
            checkOutput("stall_allowin", ms_if.ms_allowin, 1'b0);
        end
`ifdef MS_RDATA_BUF_EN
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b0, 32'h2222_2222);
`else
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b1, 32'hCAFE_F00D);
`endif
        checkOutput("stall_release_result", ms_if.ms_to_ws_bus[63:32], 32'hCAFE_F00D);
        checkOutput("stall_release_allowin", ms_if.ms_allowin, 1'b1);
        // The next load must wait for its own response, not reuse the old one
        applyStimulus(1'b1, es_word(1'b1, 3'b000, 1'b1, 1'b1, 5'd3, 32'h0000_1004, 32'h1c00_0204), 1'b1, 1'b0, 32'd0);
        checkOutput("after_stall_empty", ms_if.ms_to_ws_valid, 1'b0);
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("after_stall_wait", ms_if.ms_to_ws_valid, 1'b0);
        checkOutput("after_stall_block", ms_if.ms_to_ds_ld_block, 1'b1);
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b1, 32'h0000_0055);
        checkOutput("after_stall_result", ms_if.ms_to_ws_bus[63:32], 32'h0000_0055);

        // Back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i < 3, es_word(1'b0, 3'b000, 1'b0, 1'b1, 5'(10 + i), 32'(i * 3), 32'h1c00_0300 + 32'(i * 4)),
                          1'b1, 1'b0, 32'd0);
            checkOutput("b2b_allowin", ms_if.ms_allowin, 1'b1);
            if (i > 0) begin
                checkOutput("b2b_valid", ms_if.ms_to_ws_valid, 1'b1);
                checkOutput("b2b_pc", ms_if.ms_to_ws_bus[31:0], 32'h1c00_0300 + 32'((i - 1) * 4));
            end
        end
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("b2b_drained", ms_if.ms_to_ws_valid, 1'b0);

        // Reset while a stalled load holds its response
        applyStimulus(1'b1, es_word(1'b1, 3'b000, 1'b1, 1'b1, 5'd12, 32'h0000_2000, 32'h1c00_0400), 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 75'd0, 1'b0, 1'b1, 32'hA5A5_A5A5);
`ifdef MS_RDATA_BUF_EN
        applyStimulus(1'b0, 75'd0, 1'b0, 1'b0, 32'h0);
`else
        applyStimulus(1'b0, 75'd0, 1'b0, 1'b1, 32'hA5A5_A5A5);
`endif
        checkOutput("pre_reset_result", ms_if.ms_to_ws_bus[63:32], 32'hA5A5_A5A5);
        #2;
        resetn = 1'b0;
        ms_if.data_sram_data_ok = 1'b0;
        #1;
        checkOutput("async_rst_valid", ms_if.ms_to_ws_valid, 1'b0);
        checkOutput("async_rst_allowin", ms_if.ms_allowin, 1'b1);
        checkOutput("async_rst_dest", ms_if.ms_to_ds_dest, 5'd0);
        #1 resetn = 1'b1;
        applyStimulus(1'b0, 75'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("post_rst_valid", ms_if.ms_to_ws_valid, 1'b0);
        checkOutput("post_rst_allowin", ms_if.ms_allowin, 1'b1);
        checkOutput("post_rst_block", ms_if.ms_to_ds_ld_block, 1'b0);
        applyStimulus(1'b0, 75'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("post_rst_idle", ms_if.ms_to_ws_valid, 1'b0);

        // Random traffic: the SRAM side holds its response until the instruction leaves
        occ_valid = 1'b0;
        occ_bus   = '0;
        wait_cnt  = 0;
        resp_data = '0;
        pc        = 32'h1c01_0000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            es_valid = ($urandom_range(0, 3) != 0);
            ws       = ($urandom_range(0, 3) != 0);
            req      = $urandom_range(0, 1);
            op       = 3'($urandom_range(0, 7));
            res      = req & ($urandom_range(0, 3) != 0);
            we       = $urandom_range(0, 1);
            new_bus  = es_word(req, op, res, we, 5'($urandom_range(0, 31)), $urandom, pc);
            ok       = occ_valid & occ_bus[74] & (wait_cnt == 0);
            rdata    = ok ? resp_data : $urandom;

            applyStimulus(es_valid, new_bus, ws, ok, rdata);

            ready       = !occ_bus[74] | ok;
            exp_valid   = occ_valid & ready;
            exp_allowin = !occ_valid | (ready & ws);
            exp_final   = ref_final(occ_bus[70], occ_bus[73:71], occ_bus[63:32], rdata);
            fwd         = occ_valid & occ_bus[69];

            checkOutput("rnd_allowin", ms_if.ms_allowin, exp_allowin);
            checkOutput("rnd_valid", ms_if.ms_to_ws_valid, exp_valid);
            if (exp_valid) begin
                checkOutput("rnd_bus", ms_if.ms_to_ws_bus, {occ_bus[69], occ_bus[68:64], exp_final, occ_bus[31:0]});
            end
            checkOutput("rnd_fwd_dest", ms_if.ms_to_ds_dest, fwd ? occ_bus[68:64] : 5'd0);
            checkOutput("rnd_fwd_value", ms_if.ms_to_ds_value, fwd ? exp_final : 32'd0);
            checkOutput("rnd_ld_block", ms_if.ms_to_ds_ld_block, fwd & occ_bus[70] & !ready);

            if (exp_allowin) begin
                occ_valid = es_valid;
                if (es_valid) begin
                    occ_bus   = new_bus;
                    wait_cnt  = $urandom_range(0, 3);
                    resp_data = $urandom;
                    pc        = pc + 32'd4;
                end
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
